// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - two-requester round-robin arbiter around a repeated-add multiplier
//
// One shared engine computes P = (A * B) mod 2^WIDTH by adding A to P, B times.
// Requesters are arbitrated round-robin at capture time. Operands are latched
// at capture, so later changes to the inputs or to req_i do not affect the result.
//
// Ports:
//   clk            - clock, all state changes on rising edge
//   rst_n          - asynchronous active-low reset
//   req_i[1:0]     - per-requester multiply request
//   a0_i, b0_i     - multiplicand / multiplier of requester 0
//   a1_i, b1_i     - multiplicand / multiplier of requester 1
//   gnt_o[1:0]     - one-hot current owner while the engine is busy, 0 when idle
//   done_o[1:0]    - one-cycle completion pulse to the owner
//   p_o            - product accumulator; valid in DONE, held until next capture
//   busy_o         - high whenever the engine is not idle
module mul_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] p_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;   // requester favoured when both ask
  logic             win;
  logic [1:0]       owner_onehot;

  // A lone requester always wins; a tie goes to the pointer.
  always_comb begin
    win = ptr_q;
    case (req_i)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ptr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          a_d     = win ? a1_i : a0_i;
          b_d     = win ? b1_i : b0_i;
          p_d     = ZERO;
          owner_d = win;
          ptr_d   = ~win;
          state_d = ADD;
        end
      end
      ADD: begin
        // B counts the remaining additions; the B == 0 cycle costs one extra
        // ADD cycle, giving the fixed b + 1 latency into DONE.
        if (b_q == ZERO) begin
          state_d = DONE;
        end else begin
          p_d = p_q + a_q;
          b_d = b_q - ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= ZERO;
      b_q     <= ZERO;
      p_q     <= ZERO;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs decode straight from registers so reset clears them immediately.
  assign owner_onehot = owner_q ? 2'b10 : 2'b01;
  assign busy_o       = (state_q != IDLE);
  assign gnt_o        = busy_o ? owner_onehot : 2'b00;
  assign done_o       = (state_q == DONE) ? owner_onehot : 2'b00;
  assign p_o          = p_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - self-checking bench for mul_arbiter
module tb_mul_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt, done;
  logic [W-1:0] p;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  bit ptr_m;   // reference round-robin pointer

  always #5 clk = ~clk;

  mul_arbiter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .a0_i   (a0),
    .b0_i   (b0),
    .a1_i   (a1),
    .b1_i   (b1),
    .gnt_o  (gnt),
    .done_o (done),
    .p_o    (p),
    .busy_o (busy)
  );

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    bit           drop;
    bit           exp_owner;
    logic [W-1:0] exp_p;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One complete operation: drive, observe capture, wait for DONE, verify.
  task automatic do_op(input vec_t v);
    int           n;
    logic [1:0]   eg;
    logic [W-1:0] eb;
    eg = v.exp_owner ? 2'b10 : 2'b01;
    eb = v.exp_owner ? v.b1 : v.b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_gnt", gnt, 2'b00);
    req = v.req; a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    @(posedge clk);
    @(negedge clk);
    check("gnt_after_capture", gnt, eg);
    check("busy_after_capture", busy, 1'b1);
    if (v.drop) begin
      req = 2'b00;
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    end
    n = 0;
    while (done == 2'b00 && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check("gnt_hold", gnt, eg);
    end
    check("done_latency", n, 32'(eb) + 1);
    check("done_owner", done, eg);
    check("product", p, v.exp_p);
    req = 2'b00;
    @(negedge clk);
    check("done_one_cycle", done, 2'b00);
    check("idle_gnt_after", gnt, 2'b00);
    check("idle_busy_after", busy, 1'b0);
    check("product_held", p, v.exp_p);
    ptr_m = ~v.exp_owner;
  endtask

  task automatic plain_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 1'b0;
  endtask

  // Start an operation, assert reset partway through ADD, confirm abort.
  task automatic reset_mid(input logic [1:0] r, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    req = r; a0 = a; b0 = b; a1 = a; b1 = b;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_p", p, '0);
    req = 2'b00;
    @(negedge clk);
    check("rst_no_done", done, 2'b00);
    rst_n = 1'b1;
    ptr_m = 1'b0;
    @(negedge clk);
    check("post_rst_done", done, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         v;
    logic [31:0]  prod;
    int           grants[$];
    int           dcnt[2];
    int           done_total, cyc, last_done;
    logic [1:0]   prev_g;

    rst_n = 1'b0;
    req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    ptr_m = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_gnt", gnt, 2'b00);
    check("reset_done", done, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_p", p, '0);
    rst_n = 1'b1;

    //                req    a0        b0     a1       b1      drop own  exp_p
    vecs[0] = '{2'b11, 16'd7,    16'd2, 16'd9,   16'd4,   1'b0, 1'b0, 16'd14};
    vecs[1] = '{2'b11, 16'd7,    16'd2, 16'd9,   16'd4,   1'b0, 1'b1, 16'd36};
    vecs[2] = '{2'b01, 16'd5,    16'd3, 16'd0,   16'd0,   1'b0, 1'b0, 16'd15};
    vecs[3] = '{2'b01, 16'hFFFF, 16'd0, 16'd1,   16'd1,   1'b0, 1'b0, 16'd0};
    vecs[4] = '{2'b01, 16'h8000, 16'd2, 16'd0,   16'd0,   1'b0, 1'b0, 16'h0000};
    vecs[5] = '{2'b10, 16'd9,    16'd9, 16'd0,   16'd5,   1'b0, 1'b1, 16'd0};
    vecs[6] = '{2'b10, 16'd0,    16'd0, 16'h1234, 16'd7,  1'b1, 1'b1, 16'h7F6C};
    vecs[7] = '{2'b11, 16'd3,    16'd4, 16'd100, 16'd100, 1'b0, 1'b0, 16'd12};
    vecs[8] = '{2'b11, 16'hFFFF, 16'd3, 16'd2,   16'd6,   1'b1, 1'b1, 16'd12};
    vecs[9] = '{2'b01, 16'h0101, 16'hF, 16'd0,   16'd0,   1'b1, 1'b0, 16'h0F0F};

    for (int i = 0; i < 10; i++) do_op(vecs[i]);

    // Randomized operations against the arithmetic/round-robin model.
    for (int i = 0; i < 24; i++) begin
      v.req  = 2'($urandom_range(1, 3));
      v.a0   = W'($urandom);
      v.a1   = W'($urandom);
      v.b0   = W'($urandom_range(0, 20));
      v.b1   = W'($urandom_range(0, 20));
      v.drop = 1'($urandom_range(0, 1));
      if (v.req == 2'b01)      v.exp_owner = 1'b0;
      else if (v.req == 2'b10) v.exp_owner = 1'b1;
      else                     v.exp_owner = ptr_m;
      prod    = v.exp_owner ? (32'(v.a1) * 32'(v.b1)) : (32'(v.a0) * 32'(v.b0));
      v.exp_p = prod[W-1:0];
      do_op(v);
    end

    // Both requesters held high: strict alternation, fixed re-grant gap.
    plain_reset();
    @(negedge clk);
    a0 = 16'd2; b0 = 16'd1; a1 = 16'd3; b1 = 16'd2;
    req = 2'b11;
    dcnt[0] = 0; dcnt[1] = 0;
    done_total = 0; cyc = 0; last_done = -1; prev_g = 2'b00;
    while (done_total < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (gnt == 2'b11) check("gnt_not_both", gnt, 2'b00);
      if (gnt != 2'b00 && prev_g == 2'b00) begin
        grants.push_back(int'(gnt[1]));
        if (last_done >= 0) check("regrant_gap", cyc - last_done, 2);
      end
      if (done != 2'b00) begin
        check("held_done_owner", done, gnt);
        check("held_product", p, done[1] ? 16'd6 : 16'd2);
        dcnt[int'(done[1])]++;
        done_total++;
        last_done = cyc;
      end
      prev_g = gnt;
    end
    req = 2'b00;
    check("held_ops", done_total, 4);
    check("held_grants", grants.size(), 4);
    if (grants.size() == 4) begin
      check("held_order0", grants[0], 0);
      check("held_order1", grants[1], 1);
      check("held_order2", grants[2], 0);
      check("held_order3", grants[3], 1);
    end
    check("held_dcnt0", dcnt[0], 2);
    check("held_dcnt1", dcnt[1], 2);
    repeat (3) @(negedge clk);

    // Reset during ADD, then requester 1 alone must be served.
    reset_mid(2'b01, 16'd3, 16'd10);
    v = '{2'b10, 16'd0, 16'd0, 16'd6, 16'd7, 1'b0, 1'b1, 16'd42};
    do_op(v);

    // Reset after a capture moved the pointer: it must return to requester 0.
    reset_mid(2'b01, 16'd4, 16'd10);
    v = '{2'b11, 16'd11, 16'd3, 16'd13, 16'd2, 1'b0, 1'b0, 16'd33};
    do_op(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand and product width in bits.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The module SHALL have port req_i, input, 2, per-requester multiply request; bit k belongs to requester k.
REQ-005 The module SHALL have ports a0_i and b0_i, input, WIDTH each, multiplicand and multiplier of requester 0.
REQ-006 The module SHALL have ports a1_i and b1_i, input, WIDTH each, multiplicand and multiplier of requester 1.
REQ-007 The module SHALL have port gnt_o, output, 2, one-hot: the current owner of the shared repeated-add engine.
REQ-008 The module SHALL have port done_o, output, 2, one-cycle completion pulse to the owner.
REQ-009 The module SHALL have port p_o, output, WIDTH, the product accumulator.
REQ-010 The module SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly these states: IDLE, ADD, DONE.
REQ-012 IDLE SHALL capture at edge E0 when any req_i bit is high: A <= a_k, B <= b_k, P <= 0, owner <= k; next state ADD.
REQ-013 Arbitration SHALL be round-robin: a single requester wins regardless of priority; if both request, the priority-pointer requester wins.
REQ-014 After every capture, the priority pointer SHALL point to the non-winning requester.
REQ-015 In ADD: if B == 0, next state DONE; otherwise P <= P + A and B <= B - 1, staying in ADD.
REQ-016 DONE SHALL last exactly one cycle, then go to IDLE; done_o[owner] = 1 only in DONE.
REQ-017 Latency: DONE SHALL be entered at edge E0 + b + 1, and the engine SHALL capture again no earlier than E0 + b + 3.
REQ-018 Addition SHALL wrap modulo 2^WIDTH, with no overflow flag: p_o = (a*b) mod 2^WIDTH.
REQ-019 gnt_o SHALL be one-hot for the owner in ADD and DONE, and 0 in IDLE.
REQ-020 p_o SHALL be valid in DONE and hold its value through IDLE until the next capture edge.
REQ-021 Operands SHALL be sampled only at the capture edge; later changes to a*_i and b*_i are ignored.
REQ-022 Dropping req_i after capture SHALL NOT abort the operation; done_o still pulses.
REQ-023 Handshake: a requester SHALL deassert req_i in the cycle after its done_o; a req_i still high in IDLE counts as a new request.
REQ-024 b = 0 SHALL give DONE at E0 + 1 with p_o = 0; a = 0 SHALL take the full b + 1 ADD cycles with p_o = 0.

Reset
REQ-025 While rst_n is low: state = IDLE; A = 0, B = 0, P = 0; gnt_o = 0, done_o = 0, busy_o = 0, p_o = 0; priority pointer = requester 0.
REQ-026 Reset asserted mid-operation SHALL abort immediately, with no done_o pulse and no pointer update.
REQ-027 After rst_n rises, the first capture SHALL occur at the first rising edge with req_i != 0.

Verification
REQ-028 Requester 0 only, a0 = 5, b0 = 3 -> gnt_o = 01; done_o = 01 at E0 + 4 for one cycle; p_o = 15.
REQ-029 Both requesting from reset, (7,2) and (9,4) -> requester 0 served first (p_o = 14), then requester 1 (p_o = 36); gnt_o never 11.
REQ-030 Both held requesting for 4 operations -> grant order 0,1,0,1; each done_o pulses once per operation.
REQ-031 b0 = 0, a0 = 0xFFFF -> done_o = 01 at E0 + 1, p_o = 0; WIDTH = 16, a = 0x8000, b = 2 -> p_o = 0x0000 (wrap).
REQ-032 rst_n low during ADD with b = 10 -> outputs zero within the same cycle; no done_o; next request from requester 1 alone is granted.
REQ-033 a0_i and b0_i changed and req_i[0] dropped one cycle after capture -> result still the captured a*b; done_o[0] pulses.
